// File: rtl/alu_exec_unit.sv
`default_nettype none
// alu_exec_unit: one-cycle registered ALU stage feeding a DEPTH-entry result FIFO,
// valid/ready handshakes on both sides and a wrapping completed-operation counter.
module alu_exec_unit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      srcA,
  input  logic [31:0]      srcB,
  input  logic [2:0]       aluCtrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      aluRslt,
  output logic             zero,
  output logic             ovf,
  output logic             illegal,
  output logic [CNT_W-1:0] op_count
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = AW + 1;
  localparam int OCC_W = CW + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ANDN = 3'b100;
  localparam logic [2:0] OP_ORN  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef struct packed {
    logic [31:0] rslt;
    logic        zero;
    logic        ovf;
    logic        illegal;
  } res_t;

  logic [31:0]      sum;
  logic [31:0]      diff;
  res_t             alu_d;
  logic             accept;
  logic             push;
  logic             pop;
  logic [OCC_W-1:0] occupancy;

  res_t             s1_q;
  logic             s1_valid_q;
  res_t             mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CNT_W-1:0] op_count_q;

  assign sum  = srcA + srcB;
  assign diff = srcA - srcB;

  always_comb begin
    alu_d = '0;
    case (aluCtrl)
      OP_AND:  alu_d.rslt = srcA & srcB;
      OP_OR:   alu_d.rslt = srcA | srcB;
      OP_ADD: begin
        alu_d.rslt = sum;
        alu_d.ovf  = (srcA[31] == srcB[31]) && (sum[31] != srcA[31]);
      end
      OP_ANDN: alu_d.rslt = srcA & ~srcB;
      OP_ORN:  alu_d.rslt = srcA | ~srcB;
      OP_SUB: begin
        alu_d.rslt = diff;
        alu_d.ovf  = (srcA[31] != srcB[31]) && (diff[31] != srcA[31]);
      end
      // True signed compare; the raw subtract sign is wrong when the subtract overflows.
      OP_SLT:  alu_d.rslt = {31'd0, $signed(srcA) < $signed(srcB)};
      default: alu_d.illegal = 1'b1;
    endcase
    alu_d.zero = (alu_d.rslt == 32'd0);
  end

  // S1 plus the FIFO together never hold more than DEPTH results, so the push is never refused.
  assign occupancy = {1'b0, count_q} + {{(OCC_W-1){1'b0}}, s1_valid_q};
  assign in_ready  = (occupancy < DEPTH_OCC);
  assign accept    = in_valid & in_ready;
  assign push      = s1_valid_q;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_q <= alu_d;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= s1_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_count_q <= '0;
    end else if (pop) begin
      op_count_q <= op_count_q + CNT_W'(1);
    end
  end

  assign aluRslt  = mem_q[rd_ptr_q].rslt;
  assign zero     = mem_q[rd_ptr_q].zero;
  assign ovf      = mem_q[rd_ptr_q].ovf;
  assign illegal  = mem_q[rd_ptr_q].illegal;
  assign op_count = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// tb_alu_exec_unit: table-driven ALU vectors plus handshake corner cases, all results
// checked through an in-order scoreboard.
module tb_alu_exec_unit;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        o;
    logic        i;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  c;
    res_t        e;
  } vec_t;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      srcA;
  logic [31:0]      srcB;
  logic [2:0]       aluCtrl;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      aluRslt;
  logic             zero;
  logic             ovf;
  logic             illegal;
  logic [CNT_W-1:0] op_count;

  res_t sb_q[$];
  vec_t vt[16];
  int   n_vec   = 0;
  int   n_miss  = 0;
  int   exp_ops = 0;
  int   cyc     = 0;

  alu_exec_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .srcA(srcA), .srcB(srcB), .aluCtrl(aluCtrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .aluRslt(aluRslt), .zero(zero), .ovf(ovf), .illegal(illegal),
    .op_count(op_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // 33-bit signed reference arithmetic, independent of the DUT's formulation.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    logic signed [32:0] sa, sb, s;
    res_t m;
    sa = {a[31], a};
    sb = {b[31], b};
    m  = '0;
    case (c)
      3'b000: m.r = a & b;
      3'b001: m.r = a | b;
      3'b010: begin s = sa + sb; m.r = s[31:0]; m.o = s[32] ^ s[31]; end
      3'b100: m.r = a & ~b;
      3'b101: m.r = a | ~b;
      3'b110: begin s = sa - sb; m.r = s[31:0]; m.o = s[32] ^ s[31]; end
      3'b111: begin s = sa - sb; m.r = {31'd0, s[32]}; end
      default: m.i = 1'b1;
    endcase
    m.z = (m.r == 32'd0);
    return m;
  endfunction

  task automatic setv(input int k, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                      input logic [31:0] r, input logic z, input logic o, input logic i);
    vt[k].a = a;
    vt[k].b = b;
    vt[k].c = c;
    vt[k].e = {r, z, o, i};
  endtask

  // Scoreboard consumer: the handshake is decided by values stable at the negedge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_output: got %h, expected no output", aluRslt);
      end else begin
        check("result", {aluRslt, zero, ovf, illegal}, sb_q.pop_front());
        exp_ops++;
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c, input res_t e);
    int n;
    bit acc;
    n   = 0;
    acc = 0;
    srcA = a; srcB = b; aluCtrl = c; in_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        sb_q.push_back(e);
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_vec++;
      n_miss++;
      $display("FAIL send_timeout: in_ready stayed %b, expected 1", in_ready);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
    end
  endtask

  function automatic logic [CNT_W-1:0] exp_cnt();
    return exp_ops[CNT_W-1:0];
  endfunction

  initial begin
    logic [31:0] a, b;
    logic [2:0]  c;
    bit          took;
    bit          done;
    int          acc;
    int          t0;

    reset = 1'b1; in_valid = 1'b0; srcA = '0; srcB = '0; aluCtrl = '0; out_ready = 1'b0;

    setv(0,  32'h0AAAAA2A, 32'h04538D14, 3'b000, 32'h00028800, 0, 0, 0);
    setv(1,  32'h0AAAAA2A, 32'h04538D14, 3'b001, 32'h0EFBAF3E, 0, 0, 0);
    setv(2,  32'h0AAAAA2A, 32'h04538D14, 3'b010, 32'h0EFE373E, 0, 0, 0);
    setv(3,  32'h0AAAAA2A, 32'h04538D14, 3'b110, 32'h06571D16, 0, 0, 0);
    setv(4,  32'h0AAAAA2A, 32'h04538D14, 3'b111, 32'h00000000, 1, 0, 0);
    setv(5,  32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 0, 1, 0);
    setv(6,  32'h80000000, 32'h00000001, 3'b110, 32'h7FFFFFFF, 0, 1, 0);
    setv(7,  32'h80000000, 32'h7FFFFFFF, 3'b111, 32'h00000001, 0, 0, 0);
    setv(8,  32'h12345678, 32'h9ABCDEF0, 3'b011, 32'h00000000, 1, 0, 1);
    setv(9,  32'hFFFFFFFF, 32'h0000FFFF, 3'b000, 32'h0000FFFF, 0, 0, 0);
    setv(10, 32'hF0F0F0F0, 32'hFF00FF00, 3'b100, 32'h00F000F0, 0, 0, 0);
    setv(11, 32'h12340000, 32'hFFFF0000, 3'b101, 32'h1234FFFF, 0, 0, 0);
    setv(12, 32'h00000005, 32'hFFFFFFFD, 3'b111, 32'h00000000, 1, 0, 0);
    setv(13, 32'hFFFFFFFD, 32'h00000005, 3'b111, 32'h00000001, 0, 0, 0);
    setv(14, 32'h80000000, 32'h80000000, 3'b010, 32'h00000000, 1, 1, 0);
    setv(15, 32'h7FFFFFFF, 32'h80000000, 3'b111, 32'h00000000, 1, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_op_count",  op_count,  0);
    check("rst_head", {aluRslt, zero, ovf, illegal}, 0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // First op: visible after the second edge
    send(vt[0].a, vt[0].b, vt[0].c, vt[0].e);
    check("latency_edge1_out_valid", out_valid, 0);
    @(posedge clk); #1;
    check("latency_edge2_out_valid", out_valid, 1);
    drain();

    // Table, back-to-back: one accept per cycle
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      send(vt[i].a, vt[i].b, vt[i].c, vt[i].e);
    end
    check("throughput_cycles", cyc - t0, 16);
    drain();
    check("op_count_table", op_count, exp_cnt());

    // Backpressure: exactly DEPTH accepts, then stall until the first pop
    out_ready = 1'b0;
    a = $urandom; b = $urandom; c = 3'($urandom_range(0, 7));
    srcA = a; srcB = b; aluCtrl = c; in_valid = 1'b1;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      took = in_ready;
      if (took) begin
        sb_q.push_back(model(a, b, c));
        acc++;
      end
      @(posedge clk); #1;
      if (took) begin
        a = $urandom; b = $urandom; c = 3'($urandom_range(0, 7));
        srcA = a; srcB = b; aluCtrl = c;
      end
    end
    check("bp_accepts", acc, DEPTH);
    check("bp_in_ready_full", in_ready, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_in_ready_after_pop", in_ready, 1);
    drain();
    check("op_count_bp", op_count, exp_cnt());

    // Fill to full, then 20 random ops under random consumer stalls
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      a = $urandom; b = $urandom; c = 3'($urandom_range(0, 7));
      send(a, b, c, model(a, b, c));
    end
    check("full_in_ready", in_ready, 0);
    done = 0;
    fork
      begin
        logic [31:0] ra, rb;
        logic [2:0]  rc;
        for (int k = 0; k < 20; k++) begin
          ra = $urandom; rb = $urandom; rc = 3'($urandom_range(0, 7));
          send(ra, rb, rc, model(ra, rb, rc));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("op_count_random", op_count, exp_cnt());

    // Reset with three results buffered and one in S1
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      a = $urandom; b = $urandom; c = 3'($urandom_range(0, 7));
      send(a, b, c, model(a, b, c));
    end
    check("pre_reset_out_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    check("mid_reset_out_valid", out_valid, 0);
    check("mid_reset_in_ready",  in_ready,  1);
    check("mid_reset_op_count",  op_count,  0);
    sb_q.delete();
    exp_ops = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_reset_out_valid", out_valid, 0);
    send(vt[9].a, vt[9].b, vt[9].c, vt[9].e);
    check("post_reset_edge1_out_valid", out_valid, 0);
    @(posedge clk); #1;
    check("post_reset_edge2_out_valid", out_valid, 1);
    drain();
    check("op_count_post_reset", op_count, exp_cnt());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
# alu_exec_unit

Pipelined, handshaked ALU execution unit. It accepts operation requests (srcA, srcB, aluCtrl) from an upstream initiator over a valid/ready interface. Each result is computed and registered in one cycle, then buffered in a small output FIFO and returned over a valid/ready response interface. It sits between a sequencer or test driver and result consumers, and lets the combinational ALU semantics run under backpressure at full throughput.

## Interface
- DEPTH, 4, output FIFO entries (power of two, ≥2)
- CNT_W, 16, width of completed-operation counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request this cycle
- srcA  in  32  operand A
- srcB  in  32  operand B
- aluCtrl  in  3  operation select
- out_valid  out  1  FIFO head holds a result
- out_ready  in  1  consumer accepts head this cycle
- aluRslt  out  32  result at FIFO head
- zero  out  1  head result == 0
- ovf  out  1  signed overflow (ADD/SUB only, else 0)
- illegal  out  1  head request used reserved aluCtrl
- op_count  out  CNT_W  completed output handshakes, wraps

## Operation
- aluCtrl encoding:
  - 000 A&B
  - 001 A|B
  - 010 A+B
  - 100 A&~B
  - 101 A|~B
  - 110 A−B
  - 111 SLT signed (1 if A<B else 0)
  - 011 reserved: result 0, zero=1, illegal=1
- Arithmetic mod 2^32; carry-out discarded.
- ovf for ADD: operand signs equal and result sign differs. For SUB: operand signs differ and result sign ≠ A sign.
- SLT uses true signed compare, not the subtract sign bit: 0x80000000 < 0x7FFFFFFF → 1.
- Stage S1: on accept (in_valid & in_ready), compute and register {result, zero, ovf, illegal}; s1_valid set.
- S1 writes into the FIFO on the following edge, unconditionally; space is guaranteed by in_ready.
- in_ready = (fifo_count + s1_valid) < DEPTH.
  - Registered terms only, so there is no combinational path from out_ready to in_ready.
- Output handshake (out_valid & out_ready) pops the head and increments op_count.
- FIFO push and pop in the same cycle are legal at any occupancy, including full; the count is unchanged.
- in_valid with in_ready=0: request not accepted; the upstream must hold it.
- Inputs are ignored when in_valid=0.
- aluRslt, zero, ovf and illegal are don't-care when out_valid=0, but are driven to the head slot's content, never X after reset.

## Timing
- Reset (async assert, sync-clean deassert) values:
  - s1_valid=0, fifo_count=0, pointers=0
  - out_valid=0, in_ready=1, op_count=0
  - aluRslt=0, zero=0, ovf=0, illegal=0
- Latency: request accepted at edge N → out_valid=1 with its result after edge N+1.
- Throughput: one op per cycle sustained while out_ready=1.
- Ordering: strict FIFO; results leave in acceptance order.
- Full: fifo_count + s1_valid = DEPTH → in_ready=0 until a pop occurs.
- Reset mid-operation: S1 and all FIFO contents are discarded; no partial output.
- op_count wraps 2^CNT_W−1 → 0.

## Test plan
- srcA=0x0AAAAA2A, srcB=0x04538D14, aluCtrl sequence 000,001,010,110,111, out_ready=1 → aluRslt 0x00028800, 0x0EFBAF3E, 0x0EFE373E, 0x06571D16, 0x00000000 (zero=1 only on last). Outputs appear consecutively from 2 edges after first accept; op_count=5.
- ADD 0x7FFFFFFF+0x00000001 → 0x80000000, ovf=1. SUB 0x80000000−0x00000001 → 0x7FFFFFFF, ovf=1. SLT 0x80000000,0x7FFFFFFF → 1, ovf=0.
- aluCtrl=011 with any operands → aluRslt=0, zero=1, illegal=1. A following AND 0xFFFFFFFF&0x0000FFFF → 0x0000FFFF, illegal=0.
- Backpressure: out_ready=0, continuous in_valid → exactly DEPTH (4) accepts, then in_ready=0. Release out_ready → 4 results drain in order, and in_ready re-asserts the cycle after the first pop.
- Simultaneous push/pop at full: count stays 4, no loss or duplication across 20 randomized ops checked against a reference model.
- Assert reset while 3 results are buffered and 1 is in S1 → out_valid=0, in_ready=1, op_count=0 immediately. The first post-reset op returns after 2 edges.
